// File: rtl/dds_chirp_sweep_gen.sv
// dds_chirp_sweep_gen: linear-FM phase-increment sweep generator for a DDS core; optional phase accumulator under DDS_CHIRP_PHASE_ACC_EN
module dds_chirp_sweep_gen #(
  parameter int PHASE_W = 48,
  parameter int RATE_W  = 32,
  parameter int LEN_W   = 16
) (
  input  logic               clk_96,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [PHASE_W-1:0] cfg_delta,
  input  logic [RATE_W-1:0]  cfg_rate,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               stop,
  output logic [PHASE_W-1:0] phase_inc_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, ARM, SWEEP, DONE} state_t;
  state_t state_q, state_d;
  logic [PHASE_W-1:0] freq_q, freq_d, delta_q, delta_d, inc_q, inc_d, phase_inc_q, phase_inc_d;
  logic [RATE_W-1:0]  rate_q, rate_d, rate_cnt_q, rate_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d, step_cnt_q, step_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic cfg_loaded_q, cfg_loaded_d, start_dly_q, start_dly_d, dir_q, dir_d, hold_q, hold_d;
  logic cfg_ready_q, cfg_ready_d, out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic start_edge, step_ev, seg_end;
  // next-state logic: config capture, sweep stepping and registered outputs computed from the current state
  always_comb begin
    start_edge   = start & ~start_dly_q;
    step_ev      = state_q == SWEEP && !hold_q && rate_cnt_q == rate_q;
    seg_end      = step_cnt_q == len_q;
    state_d      = state_q;
    freq_d       = freq_q;
    delta_d      = delta_q;
    rate_d       = rate_q;
    len_d        = len_q;
    mode_d       = mode_q;
    cfg_loaded_d = cfg_loaded_q;
    start_dly_d  = start;
    inc_d        = inc_q;
    rate_cnt_d   = rate_cnt_q;
    step_cnt_d   = step_cnt_q;
    dir_d        = dir_q;
    hold_d       = hold_q;
    if (cfg_valid && cfg_ready_q) begin
      freq_d       = cfg_freq;
      delta_d      = cfg_delta;
      rate_d       = cfg_rate;
      len_d        = cfg_len;
      mode_d       = cfg_mode;
      cfg_loaded_d = 1'b1;
    end
    case (state_q)
      IDLE:  state_d = (start_edge && cfg_loaded_q && !stop) ? ARM : IDLE;
      ARM: begin
        inc_d      = freq_q;
        rate_cnt_d = '0;
        step_cnt_d = '0;
        dir_d      = 1'b0;
        hold_d     = 1'b0;
        state_d    = SWEEP;
      end
      SWEEP: begin
        rate_cnt_d = step_ev ? '0 : rate_cnt_q + 1'b1;
        if (step_ev && !seg_end) begin
          inc_d      = dir_q ? inc_q - delta_q : inc_q + delta_q;
          step_cnt_d = step_cnt_q + 1'b1;
        end else if (step_ev) begin
          state_d    = mode_q == 2'd0 ? DONE : SWEEP;
          inc_d      = mode_q == 2'd1 ? freq_q : inc_q;
          step_cnt_d = mode_q inside {2'd1, 2'd2} ? '0 : step_cnt_q;
          dir_d      = mode_q == 2'd2 ? ~dir_q : dir_q;
          hold_d     = mode_q == 2'd3;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop && state_q != IDLE) state_d = IDLE;
    out_valid_d = state_q == SWEEP && !stop;
    done_d      = state_q == DONE && !stop;
    busy_d      = state_q != IDLE && !stop;
    phase_inc_d = out_valid_d ? inc_q : '0;
    cfg_ready_d = state_d == IDLE;
  end
  // state, shadow config and output registers
  always_ff @(posedge clk_96) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      freq_q       <= '0;
      delta_q      <= '0;
      rate_q       <= '0;
      len_q        <= '0;
      mode_q       <= '0;
      cfg_loaded_q <= 1'b0;
      start_dly_q  <= 1'b0;
      inc_q        <= '0;
      rate_cnt_q   <= '0;
      step_cnt_q   <= '0;
      dir_q        <= 1'b0;
      hold_q       <= 1'b0;
      phase_inc_q  <= '0;
      cfg_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      delta_q      <= delta_d;
      rate_q       <= rate_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      cfg_loaded_q <= cfg_loaded_d;
      start_dly_q  <= start_dly_d;
      inc_q        <= inc_d;
      rate_cnt_q   <= rate_cnt_d;
      step_cnt_q   <= step_cnt_d;
      dir_q        <= dir_d;
      hold_q       <= hold_d;
      phase_inc_q  <= phase_inc_d;
      cfg_ready_q  <= cfg_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end
`ifdef DDS_CHIRP_PHASE_ACC_EN
  logic [PHASE_W-1:0] phase_q, phase_d, phase_out_q, phase_out_d;
  // accumulator restarts at zero on arm and advances by the live increment every sweep cycle
  always_comb begin
    phase_d     = state_q == ARM ? '0 : state_q == SWEEP ? phase_q + inc_q : phase_q;
    phase_out_d = out_valid_d ? phase_q : '0;
  end
  // accumulator and phase output registers
  always_ff @(posedge clk_96) begin
    if (!rst_n) begin
      phase_q     <= '0;
      phase_out_q <= '0;
    end else begin
      phase_q     <= phase_d;
      phase_out_q <= phase_out_d;
    end
  end
  assign phase_o = phase_out_q;
`else
  assign phase_o = '0;
`endif
  assign cfg_ready   = cfg_ready_q;
  assign phase_inc_o = phase_inc_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule
